bus_arbiter4_16b: RTL and testbench

//  Round-robin arbiter sharing one 16-bit bus/resource port among 4 requesters (A..D).

---
 rtl/bus_arbiter4_16b_pkg.sv | 12 +
 rtl/bus_arbiter4_16b_mux4.sv | 23 ++
 rtl/bus_arbiter4_16b.sv | 115 +++++++++++
 tb/tb_bus_arbiter4_16b.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/bus_arbiter4_16b_pkg.sv
// rtl/bus_arbiter4_16b_pkg.sv - shared state codes and pick result type for the 4-way bus arbiter
package bus_arbiter4_16b_pkg;

   localparam logic [1:0] ARB_IDLE = 2'b00;
   localparam logic [1:0] ARB_BUSY = 2'b01;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

endpackage

// File: rtl/bus_arbiter4_16b_mux4.sv
// rtl/bus_arbiter4_16b_mux4.sv - 4:1 16-bit data mux steering the granted requester onto the bus
module mux4_16b (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [15:0] c,
   input  logic [15:0] d,
   input  logic [1:0]  sel,
   output logic [15:0] o
);

   // Pure combinational select; no data registering.
   always_comb begin
      o = a;
      case (sel)
         2'd0: o = a;
         2'd1: o = b;
         2'd2: o = c;
         2'd3: o = d;
         default: o = a;
      endcase
   end

endmodule

// File: rtl/bus_arbiter4_16b.sv
// rtl/bus_arbiter4_16b.sv - round-robin arbiter granting one of four requesters a shared 16-bit bus
module bus_arbiter4_16b
   import bus_arbiter4_16b_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int HOLD_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic        ack,
   input  logic [15:0] data_a,
   input  logic [15:0] data_b,
   input  logic [15:0] data_c,
   input  logic [15:0] data_d,
   output logic [3:0]  gnt,
   output logic [1:0]  sel,
   output logic        bus_valid,
   output logic [15:0] bus_data,
   output logic        timeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [1:0]        state;
   logic [1:0]        ptr;
   logic [HOLD_W-1:0] hold_cnt;
   pick_t             pick;
   logic              rel_ack;
   logic              rel_drop;
   logic              rel_hold;
   logic              release_now;

   // First requester found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   // The loop runs from the farthest offset down so the nearest hit wins.
   function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] p);
      pick_t      res;
      logic [1:0] c;
      res = '0;
      for (int i = 3; i >= 0; i--) begin
         c = p + i[1:0];
         if (r[c]) begin
            res.found = 1'b1;
            res.idx   = c;
         end
      end
      return res;
   endfunction

   // Winner search and release conditions for the current cycle.
   always_comb begin
      pick        = rr_pick(req, ptr);
      rel_ack     = ack;
      rel_drop    = ~req[sel];
      rel_hold    = (hold_cnt == HOLD_LAST);
      release_now = rel_ack | rel_drop | rel_hold;
   end

   // Grant FSM: IDLE picks a winner, BUSY holds it until ack, drop or hold limit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB_IDLE;
         gnt       <= 4'b0000;
         sel       <= 2'b00;
         bus_valid <= 1'b0;
         timeout   <= 1'b0;
         ptr       <= 2'b00;
         hold_cnt  <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick.found) begin
                  gnt       <= 4'b0001 << pick.idx;
                  sel       <= pick.idx;
                  bus_valid <= 1'b1;
                  hold_cnt  <= '0;
                  state     <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (release_now) begin
                  gnt       <= 4'b0000;
                  sel       <= 2'b00;
                  bus_valid <= 1'b0;
                  ptr       <= sel + 2'd1;
                  hold_cnt  <= '0;
                  // Only a pure hold-limit release is reported as a timeout.
                  timeout   <= rel_hold & ~rel_ack & ~rel_drop;
                  state     <= ARB_IDLE;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: begin
               gnt       <= 4'b0000;
               sel       <= 2'b00;
               bus_valid <= 1'b0;
               hold_cnt  <= '0;
               state     <= ARB_IDLE;
            end
         endcase
      end
   end

   mux4_16b u_mux (
      .a   (data_a),
      .b   (data_b),
      .c   (data_c),
      .d   (data_d),
      .sel (sel),
      .o   (bus_data)
   );

endmodule

// File: tb/tb_bus_arbiter4_16b.sv
// tb/tb_bus_arbiter4_16b.sv - directed self-checking bench for the 4-way round-robin bus arbiter
module tb_bus_arbiter4_16b;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       ack;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       valid;
      logic       to;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic        ack;
   logic [15:0] data_a;
   logic [15:0] data_b;
   logic [15:0] data_c;
   logic [15:0] data_d;
   logic [3:0]  gnt;
   logic [1:0]  sel;
   logic        bus_valid;
   logic [15:0] bus_data;
   logic        timeout;

   int   checks  = 0;
   int   errors  = 0;
   int   step_no = 0;
   vec_t vecs[$];
   logic [15:0] dv [4];

   always #5 clk = ~clk;

   bus_arbiter4_16b #(.MAX_HOLD(16), .HOLD_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .ack       (ack),
      .data_a    (data_a),
      .data_b    (data_b),
      .data_c    (data_c),
      .data_d    (data_d),
      .gnt       (gnt),
      .sel       (sel),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input string field, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s step %0d %s: got %h want %h", tag, step_no, field, got, want);
      end
   endtask

   task automatic step(input string tag, input logic rst, input logic [3:0] r, input logic a,
                       input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic et);
      reset = rst;
      req   = r;
      ack   = a;
      @(posedge clk);
      #1;
      step_no++;
      chk(tag, "gnt",       16'(gnt),       16'(eg));
      chk(tag, "sel",       16'(sel),       16'(es));
      chk(tag, "bus_valid", 16'(bus_valid), 16'(ev));
      chk(tag, "timeout",   16'(timeout),   16'(et));
      chk(tag, "bus_data",  bus_data,       dv[es]);
   endtask

   task automatic add(input logic rst, input logic [3:0] r, input logic a,
                      input logic [3:0] eg, input logic [1:0] es, input logic ev, input logic et);
      vec_t v;
      v.rst = rst; v.req = r; v.ack = a;
      v.gnt = eg; v.sel = es; v.valid = ev; v.to = et;
      vecs.push_back(v);
   endtask

   initial begin
      logic [3:0] oh;
      logic [1:0] ix;
      data_a = 16'hA0A0;
      data_b = 16'hB1B1;
      data_c = 16'hC2C2;
      data_d = 16'hD3D3;
      dv[0] = data_a; dv[1] = data_b; dv[2] = data_c; dv[3] = data_d;
      reset = 1'b1; req = 4'b0000; ack = 1'b0;

      // reset then five idle cycles
      add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
      for (int i = 0; i < 5; i++) add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
      // single request C, ack three cycles after grant, ack in idle ignored
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
      add(0, 4'b0100, 1, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
      add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      // ptr now 3: all requesting -> D first, then ptr wraps to 0
      add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
      add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
      // rotation A,B,C,D,A with one idle cycle between grants
      for (int k = 0; k < 5; k++) begin
         ix = 2'(k % 4);
         oh = 4'b0001 << ix;
         add(0, 4'b1111, 0, oh, ix, 1, 0);
         add(0, 4'b1111, 0, oh, ix, 1, 0);
         add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
      end
      add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++)
         step("table", vecs[i].rst, vecs[i].req, vecs[i].ack,
              vecs[i].gnt, vecs[i].sel, vecs[i].valid, vecs[i].to);

      // hold limit on B: 16 grant cycles then a one-cycle timeout pulse
      step("hold", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
      for (int i = 0; i < 15; i++) step("hold", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
      step("hold_to", 0, 4'b0010, 0, 4'b0000, 0, 0, 1);
      // ptr=2, only B requests: B again, hold counter restarted
      step("regrant", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
      for (int i = 0; i < 15; i++) step("regrant", 0, 4'b0010, 0, 4'b0010, 1, 1, 0);
      // ack coincides with hold limit: no timeout pulse
      step("ack_vs_to", 0, 4'b0010, 1, 4'b0000, 0, 0, 0);
      step("ack_vs_to", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

      // D granted, drop and ack together -> one release, ptr=0
      step("d_drop", 0, 4'b1000, 0, 4'b1000, 3, 1, 0);
      step("d_drop", 0, 4'b0000, 1, 4'b0000, 0, 0, 0);
      step("d_ptr",  0, 4'b1111, 0, 4'b0001, 0, 1, 0);
      step("d_ptr",  0, 4'b1111, 1, 4'b0000, 0, 0, 0);

      // reset mid-BUSY on A (ptr was 1) clears grant and ptr
      step("rst_busy", 0, 4'b0001, 0, 4'b0001, 0, 1, 0);
      step("rst_busy", 0, 4'b0001, 0, 4'b0001, 0, 1, 0);
      step("rst_busy", 1, 4'b0001, 0, 4'b0000, 0, 0, 0);
      step("rst_after", 0, 4'b0011, 0, 4'b0001, 0, 1, 0);
      // non-winner request change ignored, then winner drop releases
      step("nonwin", 0, 4'b0111, 0, 4'b0001, 0, 1, 0);
      step("drop_a", 0, 4'b0010, 0, 4'b0000, 0, 0, 0);
      step("idle", 0, 4'b0000, 0, 4'b0000, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
